// File: rtl/axi4_lite_pkg.sv
// axi4_lite_pkg: shared response codes, FSM state type and timeout counter sizing
package axi4_lite_pkg;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   typedef enum logic [2:0] {IDLE, WR_MEM, WR_RESP, RD_MEM, RD_RESP} state_t;
   function automatic int cnt_width(input int timeout);
      return $clog2(timeout + 1);
   endfunction
endpackage

// File: rtl/axi4_lite_hold_reg.sv
// axi4_lite_hold_reg: single-entry valid/ready holding register with a clear input
//  clk_i, arstn_i : clock, asynchronous active-low reset
//  i_valid/o_ready: upstream handshake; o_ready is registered and equals ~o_full
//  i_data/o_data  : payload captured on handshake, held until the next handshake
//  i_clr          : consumer has taken the entry; frees it next cycle
//  o_full         : entry holds an unconsumed payload
module axi4_lite_hold_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             arstn_i,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_clr,
   output logic             o_ready,
   output logic             o_full,
   output logic [WIDTH-1:0] o_data
);
   logic             r_full, r_ready;
   logic [WIDTH-1:0] r_data;
   logic             w_hs, w_full_n;
   assign w_hs     = i_valid & r_ready;
   assign w_full_n = w_hs | (r_full & ~i_clr);
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         r_full  <= 1'b0;
         r_ready <= 1'b0;
         r_data  <= '0;
      end else begin
         r_full  <= w_full_n;
         r_ready <= ~w_full_n;
         if (w_hs) r_data <= i_data;
      end
   end
   assign o_ready = r_ready;
   assign o_full  = r_full;
   assign o_data  = r_data;
endmodule

// File: rtl/axi4_lite_slave.sv
// axi4_lite_slave: AXI4-Lite responder turning each transaction into one req/ack memory access
//  clk_i, arstn_i                       : clock, asynchronous active-low reset
//  aw*/w*/b*                            : AXI4-Lite write address, data and response channels
//  ar*/r*                               : AXI4-Lite read address and data channels
//  mem_req_o/mem_we_o/mem_addr_o        : memory request, held until ack or timeout; addr is window-relative
//  mem_wdata_o/mem_wstrb_o              : write data and byte enables (strobes zero on reads)
//  mem_rdata_i/mem_ack_i                : read data and single-cycle completion pulse
module axi4_lite_slave
   import axi4_lite_pkg::*;
#(
   parameter int                        AXI_ADDR_WIDTH = 64,
   parameter int                        AXI_DATA_WIDTH = 32,
   parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
   parameter logic [AXI_ADDR_WIDTH-1:0] MEM_BYTES      = AXI_ADDR_WIDTH'(64'h10000),
   parameter int                        TIMEOUT        = 16
) (
   input  logic                          clk_i,
   input  logic                          arstn_i,
   input  logic [AXI_ADDR_WIDTH-1:0]     awaddr_i,
   input  logic                          awvalid_i,
   output logic                          awready_o,
   input  logic [AXI_DATA_WIDTH-1:0]     wdata_i,
   input  logic [AXI_DATA_WIDTH/8-1:0]   wstrb_i,
   input  logic                          wvalid_i,
   output logic                          wready_o,
   output logic [1:0]                    bresp_o,
   output logic                          bvalid_o,
   input  logic                          bready_i,
   input  logic [AXI_ADDR_WIDTH-1:0]     araddr_i,
   input  logic                          arvalid_i,
   output logic                          arready_o,
   output logic [AXI_DATA_WIDTH-1:0]     rdata_o,
   output logic [1:0]                    rresp_o,
   output logic                          rvalid_o,
   input  logic                          rready_i,
   output logic                          mem_req_o,
   output logic                          mem_we_o,
   output logic [AXI_ADDR_WIDTH-1:0]     mem_addr_o,
   output logic [AXI_DATA_WIDTH-1:0]     mem_wdata_o,
   output logic [AXI_DATA_WIDTH/8-1:0]   mem_wstrb_o,
   input  logic [AXI_DATA_WIDTH-1:0]     mem_rdata_i,
   input  logic                          mem_ack_i
);
   localparam int AW = AXI_ADDR_WIDTH;
   localparam int DW = AXI_DATA_WIDTH;
   localparam int SW = DW / 8;
   localparam int SL = $clog2(SW);
   localparam int CW = cnt_width(TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   logic          w_aw_full, w_w_full, w_ar_full, w_clr_wr, w_clr_ar;
   logic [AW-1:0] w_aw_addr, w_ar_addr;
   logic [DW+SW-1:0] w_w_data;
   axi4_lite_hold_reg #(.WIDTH(AW)) u_aw (
      .clk_i(clk_i), .arstn_i(arstn_i), .i_valid(awvalid_i), .i_data(awaddr_i), .i_clr(w_clr_wr),
      .o_ready(awready_o), .o_full(w_aw_full), .o_data(w_aw_addr));
   axi4_lite_hold_reg #(.WIDTH(DW + SW)) u_w (
      .clk_i(clk_i), .arstn_i(arstn_i), .i_valid(wvalid_i), .i_data({wstrb_i, wdata_i}), .i_clr(w_clr_wr),
      .o_ready(wready_o), .o_full(w_w_full), .o_data(w_w_data));
   axi4_lite_hold_reg #(.WIDTH(AW)) u_ar (
      .clk_i(clk_i), .arstn_i(arstn_i), .i_valid(arvalid_i), .i_data(araddr_i), .i_clr(w_clr_ar),
      .o_ready(arready_o), .o_full(w_ar_full), .o_data(w_ar_addr));

   // lower bound is checked first so the subtraction cannot wrap into the window
   function automatic logic addr_ok(input logic [AW-1:0] a);
      return (a >= BASE_ADDR) && ((a - BASE_ADDR) < MEM_BYTES) && (a[SL-1:0] == '0);
   endfunction

   state_t        r_state, w_state_n;
   logic          r_prio_wr, w_prio_wr_n;
   logic [CW-1:0] r_cnt, w_cnt_n;
   logic          r_we, w_we_n;
   logic [AW-1:0] r_addr, w_addr_n;
   logic [DW-1:0] r_wdata, w_wdata_n, r_rdata, w_rdata_n;
   logic [SW-1:0] r_wstrb, w_wstrb_n;
   logic [1:0]    r_bresp, w_bresp_n, r_rresp, w_rresp_n;
   logic          w_wr_rdy, w_gnt_wr, w_gnt_rd, w_wr_ok, w_rd_ok, w_done;

   assign w_wr_rdy = w_aw_full & w_w_full;
   // on a tie the flag picks the side; it flips only when both contend
   assign w_gnt_wr = (r_state == IDLE) & w_wr_rdy & (~w_ar_full | r_prio_wr);
   assign w_gnt_rd = (r_state == IDLE) & w_ar_full & ~w_gnt_wr;
   assign w_wr_ok  = addr_ok(w_aw_addr);
   assign w_rd_ok  = addr_ok(w_ar_addr);
   // ack beats the timeout when both land in the same cycle
   assign w_done   = mem_ack_i | (r_cnt == CNT_LAST);

   always_comb begin
      w_state_n   = r_state;
      w_prio_wr_n = r_prio_wr;
      w_cnt_n     = r_cnt;
      w_we_n      = r_we;
      w_addr_n    = r_addr;
      w_wdata_n   = r_wdata;
      w_wstrb_n   = r_wstrb;
      w_bresp_n   = r_bresp;
      w_rresp_n   = r_rresp;
      w_rdata_n   = r_rdata;
      w_clr_wr    = 1'b0;
      w_clr_ar    = 1'b0;
      case (r_state)
         IDLE: begin
            w_cnt_n = '0;
            if (w_wr_rdy & w_ar_full) w_prio_wr_n = ~r_prio_wr;
            if (w_gnt_wr) begin
               w_clr_wr  = 1'b1;
               w_we_n    = 1'b1;
               w_addr_n  = w_aw_addr - BASE_ADDR;
               w_wdata_n = w_w_data[DW-1:0];
               w_wstrb_n = w_w_data[DW+:SW];
               w_bresp_n = w_wr_ok ? RESP_OKAY : RESP_SLVERR;
               w_state_n = w_wr_ok ? WR_MEM : WR_RESP;
            end else if (w_gnt_rd) begin
               w_clr_ar  = 1'b1;
               w_we_n    = 1'b0;
               w_addr_n  = w_ar_addr - BASE_ADDR;
               w_wstrb_n = '0;
               w_rresp_n = w_rd_ok ? RESP_OKAY : RESP_SLVERR;
               w_rdata_n = '0;
               w_state_n = w_rd_ok ? RD_MEM : RD_RESP;
            end
         end
         WR_MEM: begin
            w_cnt_n   = w_done ? r_cnt : r_cnt + 1'b1;
            w_bresp_n = mem_ack_i ? RESP_OKAY : RESP_SLVERR;
            w_state_n = w_done ? WR_RESP : WR_MEM;
            if (!w_done) w_bresp_n = r_bresp;
         end
         RD_MEM: begin
            w_cnt_n   = w_done ? r_cnt : r_cnt + 1'b1;
            w_rresp_n = w_done ? (mem_ack_i ? RESP_OKAY : RESP_SLVERR) : r_rresp;
            w_rdata_n = w_done ? (mem_ack_i ? mem_rdata_i : '0) : r_rdata;
            w_state_n = w_done ? RD_RESP : RD_MEM;
         end
         WR_RESP: w_state_n = bready_i ? IDLE : WR_RESP;
         RD_RESP: w_state_n = rready_i ? IDLE : RD_RESP;
         default: w_state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         r_state   <= IDLE;
         r_prio_wr <= 1'b0;
         r_cnt     <= '0;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_bresp   <= '0;
         r_rresp   <= '0;
         r_rdata   <= '0;
      end else begin
         r_state   <= w_state_n;
         r_prio_wr <= w_prio_wr_n;
         r_cnt     <= w_cnt_n;
         r_we      <= w_we_n;
         r_addr    <= w_addr_n;
         r_wdata   <= w_wdata_n;
         r_wstrb   <= w_wstrb_n;
         r_bresp   <= w_bresp_n;
         r_rresp   <= w_rresp_n;
         r_rdata   <= w_rdata_n;
      end
   end

   assign mem_req_o   = (r_state == WR_MEM) | (r_state == RD_MEM);
   assign mem_we_o    = r_we;
   assign mem_addr_o  = r_addr;
   assign mem_wdata_o = r_wdata;
   assign mem_wstrb_o = r_wstrb;
   assign bvalid_o    = r_state == WR_RESP;
   assign bresp_o     = r_bresp;
   assign rvalid_o    = r_state == RD_RESP;
   assign rresp_o     = r_rresp;
   assign rdata_o     = r_rdata;
endmodule

// File: tb/tb_axi4_lite_slave.sv
// tb_axi4_lite_slave: directed and random AXI4-Lite traffic checked against a memory/response model
module tb_axi4_lite_slave;
   localparam logic [63:0] BASE = 64'h1000;
   localparam logic [63:0] MEMB = 64'h10000;
   localparam int          TMO  = 16;

   typedef struct packed {logic we; logic [63:0] addr; logic [31:0] wd; logic [3:0] st;} mtx_t;

   logic        clk = 1'b0, arstn_i = 1'b0;
   logic [63:0] awaddr_i = '0, araddr_i = '0;
   logic        awvalid_i = 1'b0, wvalid_i = 1'b0, bready_i = 1'b0, arvalid_i = 1'b0, rready_i = 1'b0;
   logic [31:0] wdata_i = '0, mem_rdata_i = '0;
   logic [3:0]  wstrb_i = '0;
   logic        mem_ack_i = 1'b0;
   logic        awready_o, wready_o, bvalid_o, arready_o, rvalid_o, mem_req_o, mem_we_o;
   logic [1:0]  bresp_o, rresp_o;
   logic [31:0] rdata_o, mem_wdata_o;
   logic [63:0] mem_addr_o;
   logic [3:0]  mem_wstrb_o;

   int total = 0, bad = 0;
   int ack_delay = 0, req_cycles = 0, unstable = 0;
   bit acked = 1'b0;
   mtx_t cur;
   mtx_t mlog[$];
   int len_q[$];
   logic [31:0] ref_mem [logic [63:0]];
   logic [31:0] dev_mem [logic [63:0]];

   axi4_lite_slave #(.BASE_ADDR(BASE), .MEM_BYTES(MEMB), .TIMEOUT(TMO)) dut (
      .clk_i(clk), .arstn_i(arstn_i),
      .awaddr_i(awaddr_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
      .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
      .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
      .araddr_i(araddr_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
      .rdata_o(rdata_o), .rresp_o(rresp_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
      .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i));

   always #5 clk = ~clk;

   // peripheral model: logs each access, checks request stability, acks after ack_delay cycles
   always @(negedge clk) begin
      if (mem_req_o) begin
         req_cycles++;
         if (req_cycles == 1) begin
            cur = {mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o};
            mlog.push_back(cur);
         end else if ({mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o} !== cur) unstable++;
         if (!acked && ack_delay >= 0 && req_cycles == ack_delay + 1) begin
            logic [31:0] v;
            acked = 1'b1;
            mem_ack_i = 1'b1;
            v = dev_mem.exists(mem_addr_o >> 2) ? dev_mem[mem_addr_o >> 2] : 32'h0;
            if (mem_we_o) begin
               for (int b = 0; b < 4; b++) if (mem_wstrb_o[b]) v[8*b +: 8] = mem_wdata_o[8*b +: 8];
               dev_mem[mem_addr_o >> 2] = v;
            end
            mem_rdata_i = v;
         end else begin
            mem_ack_i = 1'b0;
            mem_rdata_i = $urandom;
         end
      end else begin
         if (req_cycles != 0) len_q.push_back(req_cycles);
         req_cycles = 0;
         acked = 1'b0;
         mem_ack_i = 1'b0;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit addr_ok(input logic [63:0] a);
      return (a >= BASE) && (a - BASE < MEMB) && (a[1:0] == 2'b00);
   endfunction

   function automatic logic [31:0] ref_rd(input logic [63:0] a);
      return ref_mem.exists((a - BASE) >> 2) ? ref_mem[(a - BASE) >> 2] : 32'h0;
   endfunction

   task automatic ref_wr(input logic [63:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] v;
      v = ref_rd(a);
      for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
      ref_mem[(a - BASE) >> 2] = v;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic aw_send(input logic [63:0] a);
      bit got = 1'b0;
      awaddr_i = a;
      awvalid_i = 1'b1;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         got = awready_o;
         @(posedge clk);
         #1;
      end
      awvalid_i = 1'b0;
      chk("aw_handshake", got, 1);
   endtask

   task automatic w_send(input logic [31:0] d, input logic [3:0] s);
      bit got = 1'b0;
      wdata_i = d;
      wstrb_i = s;
      wvalid_i = 1'b1;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         got = wready_o;
         @(posedge clk);
         #1;
      end
      wvalid_i = 1'b0;
      chk("w_handshake", got, 1);
   endtask

   task automatic ar_send(input logic [63:0] a);
      bit got = 1'b0;
      araddr_i = a;
      arvalid_i = 1'b1;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         got = arready_o;
         @(posedge clk);
         #1;
      end
      arvalid_i = 1'b0;
      chk("ar_handshake", got, 1);
   endtask

   task automatic b_get(output logic [1:0] r);
      bit got = 1'b0;
      r = 'x;
      bready_i = 1'b1;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (bvalid_o) begin
            got = 1'b1;
            r = bresp_o;
         end
         @(posedge clk);
         #1;
      end
      bready_i = 1'b0;
      chk("b_handshake", got, 1);
   endtask

   task automatic r_get(output logic [1:0] r, output logic [31:0] d);
      bit got = 1'b0;
      r = 'x;
      d = 'x;
      rready_i = 1'b1;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (rvalid_o) begin
            got = 1'b1;
            r = rresp_o;
            d = rdata_o;
         end
         @(posedge clk);
         #1;
      end
      rready_i = 1'b0;
      chk("r_handshake", got, 1);
   endtask

   task automatic do_write(input logic [63:0] a, input logic [31:0] d, input logic [3:0] s, input int dly);
      int n0 = mlog.size();
      bit ok = addr_ok(a);
      bit ackd = ok && dly >= 0 && dly < TMO;
      logic [1:0] br;
      ack_delay = dly;
      fork
         aw_send(a);
         w_send(d, s);
      join
      b_get(br);
      chk("bresp", br, ackd ? 2'b00 : 2'b10);
      chk("wr_mem_count", mlog.size() - n0, ok);
      if (ok && mlog.size() > n0) chk("wr_mem_op", mlog[n0], {1'b1, a - BASE, d, s});
      if (ackd) ref_wr(a, d, s);
   endtask

   task automatic do_read(input logic [63:0] a, input int dly);
      int n0 = mlog.size();
      bit ok = addr_ok(a);
      bit ackd = ok && dly >= 0 && dly < TMO;
      logic [1:0] rr;
      logic [31:0] rd;
      ack_delay = dly;
      ar_send(a);
      r_get(rr, rd);
      chk("rresp", rr, ackd ? 2'b00 : 2'b10);
      if (!ok || ackd) chk("rdata", rd, ackd ? ref_rd(a) : 32'h0);
      chk("rd_mem_count", mlog.size() - n0, ok);
      if (ok && mlog.size() > n0) chk("rd_mem_op", {mlog[n0].we, mlog[n0].addr, mlog[n0].st}, {1'b0, a - BASE, 4'h0});
   endtask

   initial begin
      int n0, kind, dly;
      bit got;
      logic [1:0] br, rr, r0;
      logic [31:0] rd, old, d0;
      logic [63:0] a;
      // reset state
      step(3);
      chk("rst_flags", {awready_o, wready_o, arready_o, bvalid_o, rvalid_o, mem_req_o, mem_we_o}, 7'h0);
      chk("rst_resp", {bresp_o, rresp_o, rdata_o}, 36'h0);
      chk("rst_mem", {mem_addr_o, mem_wdata_o, mem_wstrb_o}, 100'h0);
      arstn_i = 1'b1;
      @(negedge clk);
      chk("ready_before_first_edge", {awready_o, wready_o, arready_o}, 3'b000);
      @(negedge clk);
      chk("ready_after_release", {awready_o, wready_o, arready_o}, 3'b111);
      step(1);
      // simultaneous read and write after reset: read wins, next tie goes to the write
      a = BASE + 64'h80;
      for (int p = 0; p < 2; p++) begin
         ack_delay = 1;
         n0 = mlog.size();
         old = ref_rd(a);
         d0 = (p == 0) ? 32'h1111_2222 : 32'h3333_4444;
         fork
            aw_send(a);
            w_send(d0, 4'hF);
            ar_send(a);
         join
         fork
            b_get(br);
            r_get(rr, rd);
         join
         chk("tie_mem_count", mlog.size() - n0, 2);
         if (mlog.size() >= n0 + 2) chk("tie_order", {mlog[n0].we, mlog[n0 + 1].we}, (p == 0) ? 2'b01 : 2'b10);
         chk("tie_resps", {br, rr}, 4'b0000);
         chk("tie_rdata", rd, (p == 0) ? old : d0);
         ref_wr(a, d0, 4'hF);
      end
      // basic write then read back
      do_write(BASE + 64'h40, 32'hDEAD_BEEF, 4'hF, 2);
      do_read(BASE + 64'h40, 2);
      // zero strobe still writes, leaves data intact
      do_write(BASE + 64'h40, 32'hFFFF_FFFF, 4'h0, 0);
      do_read(BASE + 64'h40, 0);
      do_write(BASE + 64'h44, 32'hA5A5_5A5A, 4'b0101, 1);
      do_read(BASE + 64'h44, 3);
      // W before AW
      n0 = mlog.size();
      ack_delay = 1;
      w_send(32'hCAFE_F00D, 4'hF);
      @(negedge clk);
      chk("wready_low_after_w", wready_o, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("no_req_without_aw", mem_req_o, 1'b0);
      end
      step(1);
      aw_send(BASE + 64'h48);
      b_get(br);
      chk("w_first_bresp", br, 2'b00);
      chk("w_first_one_access", mlog.size() - n0, 1);
      ref_wr(BASE + 64'h48, 32'hCAFE_F00D, 4'hF);
      do_read(BASE + 64'h48, 0);
      // decode boundaries
      do_read(BASE + MEMB, 0);
      do_write(BASE + 64'h42, 32'h1234_5678, 4'hF, 0);
      do_read(BASE - 64'h4, 0);
      do_write(BASE + MEMB - 64'h4, 32'h0BAD_F00D, 4'hF, 0);
      do_read(BASE + MEMB - 64'h4, 1);
      // timeout with rready held low
      n0 = len_q.size();
      ack_delay = -1;
      ar_send(BASE + 64'h40);
      got = 1'b0;
      for (int i = 0; i < 60 && !got; i++) begin
         @(negedge clk);
         got = rvalid_o;
      end
      chk("timeout_rvalid", got, 1);
      d0 = rdata_o;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_rvalid", rvalid_o, 1'b1);
         chk("hold_rresp", rresp_o, 2'b10);
         chk("hold_rdata", rdata_o, d0);
      end
      step(1);
      r_get(rr, rd);
      chk("timeout_rresp", rr, 2'b10);
      chk("timeout_req_len", (len_q.size() > n0) ? len_q[$] : 0, TMO);
      // ack in the expiry cycle wins, one cycle later loses
      do_read(BASE + 64'h40, TMO - 1);
      chk("expiry_ack_req_len", (len_q.size() > 0) ? len_q[$] : 0, TMO);
      do_write(BASE + 64'h50, 32'h7777_8888, 4'hF, TMO);
      do_read(BASE + 64'h50, 0);
      // reset while the write is at the memory
      ack_delay = -1;
      fork
         aw_send(BASE + 64'h60);
         w_send(32'h5555_6666, 4'hF);
      join
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         got = mem_req_o;
      end
      chk("reset_req_seen", got, 1);
      @(posedge clk);
      #2;
      arstn_i = 1'b0;
      #1;
      chk("abort_outputs", {mem_req_o, bvalid_o, rvalid_o, awready_o}, 4'h0);
      #1;
      arstn_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("abort_readies", {awready_o, wready_o, arready_o}, 3'b111);
      bready_i = 1'b1;
      n0 = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n0 += int'(bvalid_o) + int'(mem_req_o);
      end
      bready_i = 1'b0;
      chk("no_b_after_abort", n0, 0);
      step(1);
      do_read(BASE + 64'h60, 0);
      // random traffic
      for (int i = 0; i < 40; i++) begin
         kind = $urandom_range(0, 11);
         dly = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 3);
         case (kind)
            0: a = BASE + 64'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
            1: a = BASE + MEMB + 64'(4 * $urandom_range(0, 3));
            2: a = BASE - 64'(4 * $urandom_range(1, 4));
            3: a = BASE + MEMB - 64'h4;
            default: a = BASE + 64'h100 + 64'(4 * $urandom_range(0, 7));
         endcase
         if ($urandom_range(0, 1) == 1) do_write(a, $urandom, 4'($urandom_range(0, 15)), dly);
         else do_read(a, dly);
      end
      chk("mem_request_stable", unstable, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
